// File: rtl/sr_noise_pkg.sv
// Shared constants for the stochastic-resonance noise scheduler:
// LFSR seeds/taps, centering and scaling constants, and the FSM encoding.
package sr_noise_pkg;

   localparam int NUM_HARMONICS = 5;

   localparam logic [NUM_HARMONICS-1:0][15:0] LFSR_SEEDS =
      {16'h92F5, 16'h1E6C, 16'hD4A9, 16'h7B3F, 16'hACE1};

   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   localparam int CENTER_OFS = 2048;
   localparam int AMP_SHIFT  = 11;

   typedef enum logic [1:0] {IDLE, STEP, COMMIT} state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/sr_amp_ramp.sv
// Next-amplitude function: moves cur toward target by at most step and
// lands exactly on target. Amplitudes are non-negative.
module sr_amp_ramp #(
   parameter int WIDTH = 18
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] next
);

   logic signed [WIDTH:0] diff;
   logic signed [WIDTH:0] step_s;

   assign diff   = $signed({1'b0, target}) - $signed({1'b0, cur});
   assign step_s = $signed({1'b0, step});

   always_comb begin
      next = target;
      if (diff > step_s)
         next = cur + step;
      else if (diff < -step_s)
         next = cur - step;
   end

endmodule

// File: rtl/sr_noise_scheduler.sv
// Time-multiplexed noise controller: one harmonic per clock after each sample
// strobe, one shared multiplier, ramped per-harmonic amplitudes.
module sr_noise_scheduler
   import sr_noise_pkg::*;
#(
   parameter int WIDTH       = 18,
   parameter int DEFAULT_AMP = 256,
   parameter int RAMP_STEP   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clk_en,
   input  logic                            cfg_we,
   input  logic [2:0]                      cfg_idx,
   input  logic [WIDTH-1:0]                cfg_amp,
   input  logic [NUM_HARMONICS-1:0]        harm_enable,
   output logic [NUM_HARMONICS*WIDTH-1:0]  noise_packed,
   output logic                            noise_valid,
   output logic                            busy,
   output logic                            overrun
);

   localparam int          PW       = 12 + WIDTH;
   localparam int          STAGES   = 1;
   localparam logic [2:0]  LAST_IDX = 3'(NUM_HARMONICS - 1);

   state_t                                   state, state_nxt;
   logic [2:0]                               idx;
   logic [NUM_HARMONICS-1:0]                 en_snap;
   logic [NUM_HARMONICS-1:0][15:0]           lfsr;
   logic [NUM_HARMONICS-1:0][WIDTH-1:0]      cur_amp;
   logic [NUM_HARMONICS-1:0][WIDTH-1:0]      target_amp;
   logic [NUM_HARMONICS-1:0][WIDTH-1:0]      staging;
   logic [STAGES:0]                          vld_pipe;

   logic [15:0]             lfsr_sel;
   logic [WIDTH-1:0]        cur_sel;
   logic [WIDTH-1:0]        tgt_sel;
   logic [WIDTH-1:0]        amp_nxt;
   logic signed [11:0]      centered;
   logic signed [PW-1:0]    prod;
   logic [WIDTH-1:0]        scaled;

   // Shared datapath: everything below is muxed by idx.
   assign lfsr_sel = lfsr[idx];
   assign cur_sel  = cur_amp[idx];
   assign tgt_sel  = target_amp[idx];
   assign centered = 12'({1'b0, lfsr_sel[11:0]} - 13'(CENTER_OFS));
   assign prod     = PW'(centered) * PW'($signed(cur_sel));
   assign scaled   = WIDTH'(prod >>> AMP_SHIFT);

   sr_amp_ramp #(.WIDTH(WIDTH)) u_ramp (
      .cur    (cur_sel),
      .target (tgt_sel),
      .step   (WIDTH'(RAMP_STEP)),
      .next   (amp_nxt)
   );

   assign busy        = (state != IDLE);
   assign noise_valid = vld_pipe[STAGES];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clk_en) state_nxt = STEP;
         STEP:    if (idx == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         en_snap      <= '0;
         staging      <= '0;
         noise_packed <= '0;
         vld_pipe     <= '0;
         overrun      <= 1'b0;
         for (int h = 0; h < NUM_HARMONICS; h++) begin
            lfsr[h]       <= LFSR_SEEDS[h];
            cur_amp[h]    <= WIDTH'(DEFAULT_AMP);
            target_amp[h] <= WIDTH'(DEFAULT_AMP);
         end
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], state == COMMIT};
         overrun  <= clk_en && (state != IDLE);
         if (state == IDLE && clk_en) begin
            en_snap <= harm_enable;
            idx     <= '0;
         end
         // LFSR and ramp advance regardless of the enable snapshot.
         if (state == STEP) begin
            lfsr[idx]    <= lfsr_next(lfsr_sel);
            cur_amp[idx] <= amp_nxt;
            staging[idx] <= en_snap[idx] ? scaled : '0;
            idx          <= idx + 3'd1;
         end
         if (vld_pipe[0])
            noise_packed <= staging;
         if (cfg_we && cfg_idx <= LAST_IDX)
            target_amp[cfg_idx] <= cfg_amp[WIDTH-1] ? '0 : cfg_amp;
      end
   end

endmodule

// File: tb/tb_sr_noise_scheduler.sv
// Bench for sr_noise_scheduler: directed scenarios plus a randomized phase,
// checked against an arithmetic reference model of the noise rules.
module tb_sr_noise_scheduler;

   localparam int W = 18;
   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           clk_en;
   logic           cfg_we;
   logic [2:0]     cfg_idx;
   logic [W-1:0]   cfg_amp;
   logic [N-1:0]   harm_enable;
   logic [N*W-1:0] noise_packed;
   logic           noise_valid;
   logic           busy;
   logic           overrun;

   int total = 0;
   int bad   = 0;

   int m_lfsr [N];
   int m_cur  [N];
   int m_tgt  [N];
   int m_out  [N];

   always #5 clk = ~clk;

   sr_noise_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_amp      (cfg_amp),
      .harm_enable  (harm_enable),
      .noise_packed (noise_packed),
      .noise_valid  (noise_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   function automatic int obs_h(input int h);
      logic signed [W-1:0] v;
      v = noise_packed[h*W +: W];
      return int'(v);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: rules computed with plain integer arithmetic.
   task automatic model_reset();
      int seeds [N];
      seeds = '{32'hACE1, 32'h7B3F, 32'hD4A9, 32'h1E6C, 32'h92F5};
      for (int h = 0; h < N; h++) begin
         m_lfsr[h] = seeds[h];
         m_cur[h]  = 256;
         m_tgt[h]  = 256;
      end
   endtask

   task automatic model_pass(input logic [N-1:0] en);
      int c, p, q, fb;
      for (int h = 0; h < N; h++) begin
         c = (m_lfsr[h] % 4096) - 2048;
         p = c * m_cur[h];
         q = (p >= 0) ? p / 2048 : -((-p + 2047) / 2048);
         m_out[h] = en[h] ? q : 0;
         fb = ((m_lfsr[h] / 32768) + (m_lfsr[h] / 8192) + (m_lfsr[h] / 4096) + (m_lfsr[h] / 1024)) % 2;
         m_lfsr[h] = ((m_lfsr[h] * 2) % 65536) + fb;
         if (m_cur[h] < m_tgt[h])
            m_cur[h] = (m_cur[h] + 4 > m_tgt[h]) ? m_tgt[h] : m_cur[h] + 4;
         else if (m_cur[h] > m_tgt[h])
            m_cur[h] = (m_cur[h] - 4 < m_tgt[h]) ? m_tgt[h] : m_cur[h] - 4;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_valid", int'(noise_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_packed_zero", int'(noise_packed == '0), 1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cfg_write(input int idx, input int amp);
      logic [31:0] a;
      a = amp;
      cfg_we  = 1'b1;
      cfg_idx = 3'(idx);
      cfg_amp = a[W-1:0];
      if (idx < N) m_tgt[idx] = (amp < 0) ? 0 : amp;
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Called at a negedge in IDLE. ovr_at = k pulses clk_en so it is sampled
   // at edge E+k (E = accepting edge); -1 for none.
   task automatic run_pass(input logic [N-1:0] en, input int ovr_at);
      model_pass(en);
      clk_en      = 1'b1;
      harm_enable = en;
      @(posedge clk);
      @(negedge clk);
      clk_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         clk_en = (k == ovr_at);
         @(posedge clk);
         @(negedge clk);
         clk_en = 1'b0;
         check($sformatf("valid_k%0d", k), int'(noise_valid), int'(k == 7));
         check($sformatf("busy_k%0d", k), int'(busy), int'(k <= 5));
         check($sformatf("overrun_k%0d", k), int'(overrun), int'(k == ovr_at));
         if (k >= 7)
            for (int h = 0; h < N; h++)
               check($sformatf("noise_h%0d_k%0d", h, k), obs_h(h), m_out[h]);
      end
   endtask

   task automatic check_gold(input string tag, input int g0, input int g1,
                             input int g2, input int g3, input int g4);
      check({tag, "_h0"}, obs_h(0), g0);
      check({tag, "_h1"}, obs_h(1), g1);
      check({tag, "_h2"}, obs_h(2), g2);
      check({tag, "_h3"}, obs_h(3), g3);
      check({tag, "_h4"}, obs_h(4), g4);
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_amp = '0;
      harm_enable = '0;
      model_reset();

      // Golden single pass, all enabled
      do_reset();
      run_pass(5'b11111, -1);
      check_gold("gold_all", 156, 103, -107, 205, -162);

      // Partial enable; disabled LFSRs still advance
      do_reset();
      run_pass(5'b00101, -1);
      check_gold("gold_00101", 156, 0, -107, 0, 0);
      run_pass(5'b11111, -1);

      // Ramp up to 300 then down to 10 on harmonic 3
      do_reset();
      cfg_write(3, 300);
      for (int i = 0; i < 20; i++) run_pass(5'b11111, -1);
      cfg_write(3, 10);
      for (int i = 0; i < 76; i++) run_pass(5'b01000, -1);
      check("ramp_down_landed", m_cur[3], 10);

      // Overrun mid-pass and coincident with COMMIT
      do_reset();
      run_pass(5'b11111, 3);
      check_gold("gold_ovr", 156, 103, -107, 205, -162);
      run_pass(5'b10110, 6);
      run_pass(5'b11111, 1);

      // Reset during STEP idx 2 aborts the pass
      clk_en = 1'b1; harm_enable = 5'b11111;
      @(posedge clk);
      @(negedge clk);
      clk_en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst_packed_zero", int'(noise_packed == '0), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_overrun", int'(overrun), 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("midrst_valid", int'(noise_valid), 0);
      end
      rst = 1'b0;
      @(negedge clk);
      run_pass(5'b11111, -1);
      check_gold("gold_after_midrst", 156, 103, -107, 205, -162);

      // Out-of-range index ignored; negative target clamps to 0
      cfg_write(6, 999);
      cfg_write(0, -50);
      for (int i = 0; i < 65; i++) run_pass(5'b11111, -1);
      check("h0_faded_to_zero", obs_h(0), 0);
      check("h1_untouched_amp", m_cur[1], 256);

      // Randomized phase
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(1) == 1)
            cfg_write(int'($urandom_range(7)), int'($urandom_range(600)) - 100);
         run_pass(5'($urandom_range(31)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(6, 1)) : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
